// File: rtl/sram_pkg.sv
// Shared types and default constants for the asynchronous SRAM controller.
package sram_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_HOLD   = 2'd3
   } sram_state_e;

   localparam int DEF_ADDR_WIDTH  = 8;
   localparam int DEF_DATA_WIDTH  = 8;
   localparam int DEF_WAIT_CYCLES = 1;

   // Wide enough for the largest allowed wait count of 15.
   localparam int CNT_WIDTH = 4;

endpackage

// File: rtl/sram_ctrl.sv
// Single-port asynchronous SRAM controller: setup / strobe / hold sequencing.
// Define SRAM_CTRL_ASSERT_EN to compile the built-in protocol assertions.
//
// state  | meaning
// IDLE   | ready for a request, bus released
// SETUP  | address and chip select out, write data on bus, we_n still high
// ACCESS | strobe (we_n or oe_n) low for WAIT_CYCLES cycles
// HOLD   | strobes released, address/data held, one-cycle response
module sram_ctrl
   import sram_pkg::*;
#(
   parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_req_valid,
   output logic                  o_req_ready,
   input  logic                  i_req_we,
   input  logic [ADDR_WIDTH-1:0] i_req_addr,
   input  logic [DATA_WIDTH-1:0] i_req_wdata,
   output logic                  o_rsp_valid,
   output logic [DATA_WIDTH-1:0] o_rsp_rdata,
   output logic [ADDR_WIDTH-1:0] o_sram_addr,
   output logic                  o_sram_cs_n,
   output logic                  o_sram_we_n,
   output logic                  o_sram_oe_n,
   inout  wire  [DATA_WIDTH-1:0] bi_sram_data
);

   localparam logic [CNT_WIDTH-1:0] WAIT_M1 = CNT_WIDTH'(WAIT_CYCLES - 1);

   sram_state_e            state_q, state_d;
   logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
   logic                   we_q;
   logic [ADDR_WIDTH-1:0]  addr_q;
   logic [DATA_WIDTH-1:0]  wdata_q;
   logic [DATA_WIDTH-1:0]  rdata_q;
   logic                   cs_n_q, we_n_q, oe_n_q, drive_q, rsp_valid_q;
   logic                   cs_n_d, we_n_d, oe_n_d, drive_d, rsp_valid_d;
   logic                   accept;
   logic                   op_we;
   logic                   last_read_access;

   assign accept           = i_req_valid && (state_q == ST_IDLE);
   assign op_we            = accept ? i_req_we : we_q;
   assign last_read_access = (state_q == ST_ACCESS) && (cnt_q == '0) && !we_q;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Strobes are decoded from the next state and registered so the pins
   // change only on the clock edge.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      cs_n_d      = 1'b1;
      we_n_d      = 1'b1;
      oe_n_d      = 1'b1;
      drive_d     = 1'b0;
      rsp_valid_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (accept) state_d = ST_SETUP;
         end
         ST_SETUP: begin
            state_d = ST_ACCESS;
            cnt_d   = WAIT_M1;
         end
         ST_ACCESS: begin
            if (cnt_q == '0) state_d = ST_HOLD;
            else             cnt_d   = cnt_q - 1'b1;
         end
         ST_HOLD: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase

      case (state_d)
         ST_SETUP: begin
            cs_n_d  = 1'b0;
            oe_n_d  = op_we;
            drive_d = op_we;
         end
         ST_ACCESS: begin
            cs_n_d  = 1'b0;
            oe_n_d  = op_we;
            we_n_d  = !op_we;
            drive_d = op_we;
         end
         ST_HOLD: begin
            drive_d     = op_we;
            rsp_valid_d = 1'b1;
         end
         default: begin
            drive_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cs_n_q      <= 1'b1;
         we_n_q      <= 1'b1;
         oe_n_q      <= 1'b1;
         drive_q     <= 1'b0;
         rsp_valid_q <= 1'b0;
      end else begin
         cs_n_q      <= cs_n_d;
         we_n_q      <= we_n_d;
         oe_n_q      <= oe_n_d;
         drive_q     <= drive_d;
         rsp_valid_q <= rsp_valid_d;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else if (accept) begin
         we_q    <= i_req_we;
         addr_q  <= i_req_addr;
         wdata_q <= i_req_wdata;
      end
   end

   // Sampled at the edge that ends the final strobe cycle, while oe_n is still low.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)              rdata_q <= '0;
      else if (last_read_access) rdata_q <= bi_sram_data;
   end

   assign bi_sram_data = drive_q ? wdata_q : {DATA_WIDTH{1'bz}};

   assign o_req_ready = (state_q == ST_IDLE);
   assign o_rsp_valid = rsp_valid_q;
   assign o_rsp_rdata = rdata_q;
   assign o_sram_addr = addr_q;
   assign o_sram_cs_n = cs_n_q;
   assign o_sram_we_n = we_n_q;
   assign o_sram_oe_n = oe_n_q;

`ifdef SRAM_CTRL_ASSERT_EN
   a_no_we_oe_overlap: assert property (@(posedge i_clk) disable iff (!i_rst_n)
      !(!we_n_q && !oe_n_q));

   a_rsp_single_cycle: assert property (@(posedge i_clk) disable iff (!i_rst_n)
      rsp_valid_q |=> !rsp_valid_q);

   a_no_drive_on_read: assert property (@(posedge i_clk) disable iff (!i_rst_n)
      !(drive_q && !oe_n_q));
`else
   // Protocol checks are left out of this build.
`endif

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl: two instances (WAIT_CYCLES 1 and 4), each with an async SRAM model.
module tb_sram_ctrl;

   logic clk;
   logic rst_n;

   logic       a_valid, a_ready, a_we, a_rsp, a_cs_n, a_we_n, a_oe_n;
   logic [7:0] a_addr_in, a_wdata, a_rdata, a_addr;
   wire  [7:0] a_bus;

   logic       b_valid, b_ready, b_we, b_rsp, b_cs_n, b_we_n, b_oe_n;
   logic [7:0] b_addr_in, b_wdata, b_rdata, b_addr;
   wire  [7:0] b_bus;

   logic [7:0] a_mem [256];
   logic [7:0] b_mem [256];

   int n_cmp = 0;
   int n_err = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   sram_ctrl #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .WAIT_CYCLES(1)) u_dut_a (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_req_valid(a_valid), .o_req_ready(a_ready), .i_req_we(a_we),
      .i_req_addr(a_addr_in), .i_req_wdata(a_wdata),
      .o_rsp_valid(a_rsp), .o_rsp_rdata(a_rdata),
      .o_sram_addr(a_addr), .o_sram_cs_n(a_cs_n), .o_sram_we_n(a_we_n),
      .o_sram_oe_n(a_oe_n), .bi_sram_data(a_bus)
   );

   sram_ctrl #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .WAIT_CYCLES(4)) u_dut_b (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_req_valid(b_valid), .o_req_ready(b_ready), .i_req_we(b_we),
      .i_req_addr(b_addr_in), .i_req_wdata(b_wdata),
      .o_rsp_valid(b_rsp), .o_rsp_rdata(b_rdata),
      .o_sram_addr(b_addr), .o_sram_cs_n(b_cs_n), .o_sram_we_n(b_we_n),
      .o_sram_oe_n(b_oe_n), .bi_sram_data(b_bus)
   );

   // Async SRAM models: drive on cs_n/oe_n low, store while cs_n/we_n low.
   assign a_bus = (!a_cs_n && !a_oe_n && a_we_n) ? a_mem[a_addr] : 8'hzz;
   assign b_bus = (!b_cs_n && !b_oe_n && b_we_n) ? b_mem[b_addr] : 8'hzz;

   always @(negedge clk) if (!a_cs_n && !a_we_n) a_mem[a_addr] <= a_bus;
   always @(negedge clk) if (!b_cs_n && !b_we_n) b_mem[b_addr] <= b_bus;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // A released bus reads as Z (4-state) or 0 (2-state resolution); any write data here is nonzero.
   function automatic logic bus_idle(input logic [7:0] v);
      return (v === 8'hzz) || (v === 8'h00);
   endfunction

   initial begin
      rst_n = 1'b0;
      a_valid = 1'b0; a_we = 1'b0; a_addr_in = '0; a_wdata = '0;
      b_valid = 1'b0; b_we = 1'b0; b_addr_in = '0; b_wdata = '0;

      repeat (2) @(negedge clk);
      chk("rst_a_ready", a_ready, 1);
      chk("rst_a_strobes", {a_cs_n, a_we_n, a_oe_n}, 3'b111);
      chk("rst_a_rsp", a_rsp, 0);
      chk("rst_a_rdata", a_rdata, 8'h00);
      chk("rst_a_addr", a_addr, 8'h00);
      chk("rst_a_bus_idle", bus_idle(a_bus), 1);
      chk("rst_b_strobes", {b_cs_n, b_we_n, b_oe_n}, 3'b111);

      // Write 0xA5 to 0x3C, accepted on the first edge after reset release.
      rst_n = 1'b1;
      a_valid = 1'b1; a_we = 1'b1; a_addr_in = 8'h3C; a_wdata = 8'hA5;
      @(negedge clk);
      chk("wr_setup_strobes", {a_cs_n, a_we_n, a_oe_n}, 3'b011);
      chk("wr_setup_bus", a_bus, 8'hA5);
      chk("wr_setup_addr", a_addr, 8'h3C);
      chk("wr_setup_ready", a_ready, 0);
      a_valid = 1'b0;
      @(negedge clk);
      chk("wr_access_strobes", {a_cs_n, a_we_n, a_oe_n}, 3'b001);
      chk("wr_access_bus", a_bus, 8'hA5);
      chk("wr_access_rsp", a_rsp, 0);
      @(negedge clk);
      chk("wr_hold_strobes", {a_cs_n, a_we_n, a_oe_n}, 3'b111);
      chk("wr_hold_rsp", a_rsp, 1);
      chk("wr_hold_bus", a_bus, 8'hA5);
      chk("wr_hold_addr", a_addr, 8'h3C);
      @(negedge clk);
      chk("wr_done_ready", a_ready, 1);
      chk("wr_done_rsp", a_rsp, 0);
      chk("wr_done_bus_idle", bus_idle(a_bus), 1);

      // Read back 0x3C; wdata set to a different value to expose any bus contention.
      a_valid = 1'b1; a_we = 1'b0; a_addr_in = 8'h3C; a_wdata = 8'h5A;
      @(negedge clk);
      chk("rd_setup_strobes", {a_cs_n, a_we_n, a_oe_n}, 3'b010);
      chk("rd_setup_bus", a_bus, 8'hA5);
      a_valid = 1'b0;
      @(negedge clk);
      chk("rd_access_strobes", {a_cs_n, a_we_n, a_oe_n}, 3'b010);
      chk("rd_access_rsp", a_rsp, 0);
      @(negedge clk);
      chk("rd_hold_rsp", a_rsp, 1);
      chk("rd_hold_rdata", a_rdata, 8'hA5);
      chk("rd_hold_strobes", {a_cs_n, a_we_n, a_oe_n}, 3'b111);
      chk("rd_hold_bus_idle", bus_idle(a_bus), 1);
      @(negedge clk);
      chk("rd_done_ready", a_ready, 1);
      chk("rd_done_rsp", a_rsp, 0);

      // Valid held while busy with a changing address: only the latched write runs.
      a_valid = 1'b1; a_we = 1'b1; a_addr_in = 8'h10; a_wdata = 8'h77;
      @(negedge clk);
      chk("hold_setup_addr", a_addr, 8'h10);
      chk("hold_setup_strobes", {a_cs_n, a_we_n, a_oe_n}, 3'b011);
      a_addr_in = 8'h20; a_wdata = 8'h88;
      @(negedge clk);
      chk("hold_access_addr", a_addr, 8'h10);
      chk("hold_access_bus", a_bus, 8'h77);
      a_addr_in = 8'h30;
      @(negedge clk);
      chk("hold_hold_rsp", a_rsp, 1);
      a_valid = 1'b0;
      @(negedge clk);
      chk("hold_idle_rsp", a_rsp, 0);
      chk("hold_idle_ready", a_ready, 1);
      @(negedge clk);
      chk("hold_no_second_rsp", a_rsp, 0);
      chk("hold_no_second_strobe", {a_cs_n, a_we_n, a_oe_n}, 3'b111);
      a_valid = 1'b1; a_we = 1'b0; a_addr_in = 8'h10; a_wdata = 8'h00;
      @(negedge clk);
      a_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("hold_readback_rsp", a_rsp, 1);
      chk("hold_readback_rdata", a_rdata, 8'h77);
      @(negedge clk);

      // Reset pulsed during the strobe cycle of a write.
      a_valid = 1'b1; a_we = 1'b1; a_addr_in = 8'h44; a_wdata = 8'hEE;
      @(negedge clk);
      a_valid = 1'b0;
      @(negedge clk);
      chk("abort_pre_strobes", {a_cs_n, a_we_n, a_oe_n}, 3'b001);
      #1 rst_n = 1'b0;
      #1;
      chk("abort_strobes", {a_cs_n, a_we_n, a_oe_n}, 3'b111);
      chk("abort_bus_idle", bus_idle(a_bus), 1);
      chk("abort_rsp", a_rsp, 0);
      chk("abort_rdata", a_rdata, 8'h00);
      chk("abort_addr", a_addr, 8'h00);
      chk("abort_ready", a_ready, 1);
      @(negedge clk);
      chk("abort_rsp_later", a_rsp, 0);
      rst_n = 1'b1;
      a_valid = 1'b1; a_we = 1'b1; a_addr_in = 8'h44; a_wdata = 8'h99;
      @(negedge clk);
      chk("post_setup_strobes", {a_cs_n, a_we_n, a_oe_n}, 3'b011);
      a_valid = 1'b0;
      @(negedge clk);
      chk("post_access_strobes", {a_cs_n, a_we_n, a_oe_n}, 3'b001);
      @(negedge clk);
      chk("post_hold_rsp", a_rsp, 1);
      chk("post_wr_rdata_kept", a_rdata, 8'h00);
      @(negedge clk);
      a_valid = 1'b1; a_we = 1'b0; a_addr_in = 8'h44;
      @(negedge clk);
      a_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("post_rd_rsp", a_rsp, 1);
      chk("post_rd_rdata", a_rdata, 8'h99);

      // WAIT_CYCLES=4: write 0x11 to 0x00 with a read of 0x00 queued behind it.
      b_valid = 1'b1; b_we = 1'b1; b_addr_in = 8'h00; b_wdata = 8'h11;
      @(negedge clk);
      chk("b_wr_setup_strobes", {b_cs_n, b_we_n, b_oe_n}, 3'b011);
      b_we = 1'b0; b_wdata = 8'hFF;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk($sformatf("b_wr_access%0d_strobes", k), {b_cs_n, b_we_n, b_oe_n}, 3'b001);
         chk($sformatf("b_wr_access%0d_ready", k), b_ready, 0);
      end
      @(negedge clk);
      chk("b_wr_hold_rsp", b_rsp, 1);
      chk("b_wr_hold_strobes", {b_cs_n, b_we_n, b_oe_n}, 3'b111);
      chk("b_wr_hold_ready", b_ready, 0);
      @(negedge clk);
      chk("b_accept2_ready", b_ready, 1);
      chk("b_accept2_rsp", b_rsp, 0);
      @(negedge clk);
      chk("b_rd_setup_strobes", {b_cs_n, b_we_n, b_oe_n}, 3'b010);
      chk("b_rd_setup_bus", b_bus, 8'h11);
      b_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk($sformatf("b_rd_access%0d_strobes", k), {b_cs_n, b_we_n, b_oe_n}, 3'b010);
      end
      @(negedge clk);
      chk("b_rd_hold_rsp", b_rsp, 1);
      chk("b_rd_hold_rdata", b_rdata, 8'h11);
      @(negedge clk);
      chk("b_rd_done_rsp", b_rsp, 0);
      chk("b_rd_done_ready", b_ready, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
